// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one integer divider among
// N_REQ requesters. Handles divide-by-zero locally and aborts a divider that
// fails to report completion within TIMEOUT cycles.
module div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   dividend_in,
  input  logic [N_REQ*WIDTH-1:0]   divisor_in,
  output logic [N_REQ-1:0]         ack,
  output logic [WIDTH-1:0]         quotient_out,
  output logic [WIDTH-1:0]         remainder_out,
  output logic                     err_out,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     div_go,
  output logic                     div_rst,
  output logic [WIDTH-1:0]         div_x,
  output logic [WIDTH-1:0]         div_y,
  input  logic                     div_done,
  input  logic [WIDTH-1:0]         div_q,
  input  logic [WIDTH-1:0]         div_r
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [GW-1:0]     grant_r;
  logic [GW-1:0]     last_grant_r;
  logic              first_idle_r;   // high during the first IDLE cycle after RESP
  logic [WIDTH-1:0]  op_x_r;
  logic [WIDTH-1:0]  op_y_r;
  logic [CW-1:0]     cnt_r;
  logic [N_REQ-1:0]  ack_r;
  logic [WIDTH-1:0]  q_r;
  logic [WIDTH-1:0]  r_r;
  logic              err_r;
  logic              div_go_r;

  logic [N_REQ-1:0]  mask_s;
  logic [N_REQ-1:0]  elig_s;
  logic              found_s;
  logic [GW-1:0]     pick_s;
  logic [WIDTH-1:0]  sel_x_s;
  logic [WIDTH-1:0]  sel_y_s;
  logic [CW-1:0]     cnt_inc_s;
  logic              timeout_s;

  // Round-robin search starting just after the last served requester;
  // the last served requester is masked for one IDLE cycle after its ack.
  always_comb begin
    mask_s  = first_idle_r ? ({{(N_REQ-1){1'b0}}, 1'b1} << last_grant_r) : {N_REQ{1'b0}};
    elig_s  = req & ~mask_s;
    found_s = 1'b0;
    pick_s  = {GW{1'b0}};
    for (int i = 1; i <= N_REQ; i++) begin
      int  idx;
      logic hit;
      idx     = (int'(last_grant_r) + i) % N_REQ;
      hit     = elig_s[idx] & ~found_s;
      pick_s  = hit ? GW'(idx) : pick_s;
      found_s = found_s | hit;
    end
    sel_x_s = dividend_in[int'(pick_s)*WIDTH +: WIDTH];
    sel_y_s = divisor_in[int'(pick_s)*WIDTH +: WIDTH];
  end

  // Watchdog increment that saturates at TIMEOUT.
  always_comb begin
    cnt_inc_s = (cnt_r == CW'(TIMEOUT)) ? cnt_r : cnt_r + {{(CW-1){1'b0}}, 1'b1};
  end

  // Next-state logic and watchdog abort detection.
  always_comb begin
    next_state_s = state_r;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          next_state_s = (sel_y_s == {WIDTH{1'b0}}) ? RESP : ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: next_state_s = WAIT;
      WAIT: begin
        if (div_done) begin
          next_state_s = RESP;
        end else if (cnt_inc_s == CW'(TIMEOUT)) begin
          next_state_s = RESP;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Grant bookkeeping, operand latches, watchdog counter and start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r      <= {GW{1'b0}};
      last_grant_r <= GW'(N_REQ - 1);
      first_idle_r <= 1'b0;
      op_x_r       <= {WIDTH{1'b0}};
      op_y_r       <= {WIDTH{1'b0}};
      cnt_r        <= {CW{1'b0}};
      div_go_r     <= 1'b0;
    end else begin
      div_go_r <= (next_state_s == ISSUE);
      case (state_r)
        IDLE: begin
          first_idle_r <= 1'b0;
          if (found_s) begin
            grant_r <= pick_s;
            op_x_r  <= sel_x_s;
            op_y_r  <= sel_y_s;
          end
        end
        ISSUE: cnt_r <= {CW{1'b0}};
        WAIT:  cnt_r <= cnt_inc_s;
        RESP: begin
          last_grant_r <= grant_r;
          first_idle_r <= 1'b1;
        end
        default: first_idle_r <= 1'b0;
      endcase
    end
  end

  // Result registers and the one-cycle ack toward the granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r <= {N_REQ{1'b0}};
      q_r   <= {WIDTH{1'b0}};
      r_r   <= {WIDTH{1'b0}};
      err_r <= 1'b0;
    end else begin
      ack_r <= {N_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (found_s && (sel_y_s == {WIDTH{1'b0}})) begin
            q_r           <= {WIDTH{1'b1}};
            r_r           <= sel_x_s;
            err_r         <= 1'b1;
            ack_r[pick_s] <= 1'b1;
          end
        end
        WAIT: begin
          if (div_done) begin
            q_r            <= div_q;
            r_r            <= div_r;
            err_r          <= 1'b0;
            ack_r[grant_r] <= 1'b1;
          end else if (timeout_s) begin
            q_r            <= {WIDTH{1'b0}};
            r_r            <= {WIDTH{1'b0}};
            err_r          <= 1'b1;
            ack_r[grant_r] <= 1'b1;
          end
        end
        default: err_r <= err_r;
      endcase
    end
  end

  assign ack           = ack_r;
  assign quotient_out  = q_r;
  assign remainder_out = r_r;
  assign err_out       = err_r;
  assign busy          = (state_r != IDLE);
  assign grant_id      = grant_r;
  assign div_go        = div_go_r;
  assign div_rst       = rst | timeout_s;
  assign div_x         = op_x_r;
  assign div_y         = op_y_r;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin scheduler that shares one integer divider datapath and its control unit among N requesters. It accepts per-requester dividend/divisor requests and launches the divider with a one-cycle `go`. It waits for `done`, then returns quotient/remainder with a one-cycle `ack` to the granted requester. Divide-by-zero is handled without starting the divider, and a watchdog recovers from a hung divider.

## Interface
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 4, operand/result width in bits
- TIMEOUT, 31, max WAIT cycles before abort (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  per-requester request level
- dividend_in  in  N_REQ*WIDTH  requester i dividend at bits [i*WIDTH +: WIDTH]
- divisor_in  in  N_REQ*WIDTH  requester i divisor, same packing
- ack  out  N_REQ  one-hot, one-cycle completion pulse
- quotient_out  out  WIDTH  result, valid while ack≠0
- remainder_out  out  WIDTH  result, valid while ack≠0
- err_out  out  1  error flag, valid while ack≠0 (divide-by-zero or timeout)
- busy  out  1  high in every state except IDLE
- grant_id  out  clog2(N_REQ)  index of current/last granted requester
- div_go  out  1  start pulse to divider control unit
- div_rst  out  1  reset to divider datapath/control unit
- div_x  out  WIDTH  dividend to divider
- div_y  out  WIDTH  divisor to divider
- div_done  in  1  divider completion
- div_q  in  WIDTH  divider quotient
- div_r  in  WIDTH  divider remainder

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any eligible req, pick first set bit searching from (last_grant+1) mod N_REQ upward with wrap. Latch grant_id, dividend, divisor into internal registers. Next state: RESP with err=1 if the latched divisor==0, else ISSUE.
- Divide-by-zero result: quotient=all ones, remainder=dividend, err=1; divider not started.
- ISSUE: div_go=1 for exactly this cycle; clear watchdog counter. Next state: WAIT.
- WAIT: counter increments each cycle. On div_done=1, latch div_q/div_r, err=0, next state RESP. Else if counter==TIMEOUT: quotient=0, remainder=0, err=1, div_rst=1 this cycle, next state RESP. div_done takes priority when both occur in the same cycle.
- RESP: ack[grant_id]=1 and results driven for one cycle; last_grant←grant_id; next state IDLE.
- div_x/div_y hold latched operands from ISSUE through WAIT, stable while divider runs.
- Eligibility: in the first IDLE cycle after RESP, req[last_grant] is masked. It is eligible again from the second IDLE cycle.
- Requests are sampled only at grant. Operand changes or req deassertion after grant are ignored, and the ack is still issued.
- Counter width clog2(TIMEOUT+1); no wrap, saturates at TIMEOUT.
- div_rst = rst OR timeout pulse.

## Timing
- Reset (edge with rst=1): state IDLE, ack=0, quotient_out=0, remainder_out=0, err_out=0, busy=0, grant_id=0, div_go=0, div_x=0, div_y=0, counter=0, last_grant=N_REQ-1 (requester 0 wins first). div_rst=1 during rst.
- rst mid-operation (any state): IDLE on the next edge; pending request dropped with no ack; div_go=0.
- Normal latency: req sampled at edge E0 → ISSUE during cycle after E0 (div_go high) → WAIT. div_done sampled at edge Ed → ack high in cycle after Ed.
- Divide-by-zero latency: grant at edge E0 → ack high in cycle after E0.
- Timeout: ack high TIMEOUT+1 cycles after ISSUE cycle.
- Back-to-back: minimum 4 cycles per divider transaction, plus the divider's own latency.
- No new grant while busy; simultaneous requests serviced one per transaction in round-robin order.

## Test plan
- Single request: req=0001, dividend0=13, divisor0=4, divider model done after 10 cycles → div_go one pulse, div_x=13, div_y=4; ack=0001 with q=3, r=1, err=0.
- Divide-by-zero: req=0100, dividend2=9, divisor2=0 → no div_go; ack=0100 one cycle after grant, q=1111, r=1001, err=1.
- Contention: req=1111 held, each re-asserted after its ack → grant order 0,1,2,3,0; each ack one-hot, no requester served twice in a row.
- Fairness: req[0] re-asserted immediately after its ack, req[3] pending → requester 3 granted next.
- Watchdog: divider model never asserts done, TIMEOUT=31 → div_rst pulse, ack with q=0, r=0, err=1; next request then completes normally.
- Reset in WAIT: rst=1 for one cycle mid-divide → busy=0, no ack, div_go=0 next cycle; a following request is granted to requester 0 and completes correctly.
